// File: rtl/sc_game_pkg.sv
// Shared constants and state encoding for the game-event controller
// that feeds the background state machine.
package sc_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_NEST,
        ST_LEVELUP,
        ST_DEAD,
        ST_GAMEOVER
    } state_e;

    localparam int unsigned DEF_NESTS      = 5;
    localparam int unsigned DEF_LIVES_INIT = 3;
    localparam int unsigned DEF_LEVEL_MAX  = 4;
    localparam int unsigned DEF_TICK_BASE  = 25000000;
    localparam int unsigned DEF_TICK_STEP  = 5000000;

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned LIVES_W = 2;

    // Scroll period in clocks for a given level.
    function automatic int unsigned tick_period(input int unsigned base,
                                                input int unsigned step,
                                                input int unsigned level);
        return base - level * step;
    endfunction

endpackage

// File: rtl/sc_tick_gen.sv
// Loadable down-counter producing a 1-clk active-low tick every
// period_i enabled clocks.
module sc_tick_gen #(
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned RST_VAL = 24999999
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_no_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_no_q, tick_no_d;

    always_comb begin
        cnt_d     = cnt_q;
        tick_no_d = 1'b1;
        if (load_i) begin
            cnt_d = period_i - CNT_W'(1);
        end else if (en_i) begin
            if (cnt_q == '0) begin
                tick_no_d = 1'b0;
                cnt_d     = period_i - CNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= CNT_W'(RST_VAL);
            tick_no_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            tick_no_q <= tick_no_d;
        end
    end

    assign tick_no_o = tick_no_q;

endmodule

// File: rtl/sc_level_ctrl.sv
// Game-event controller: tracks nests, lives and level and emits the
// scroll tick and event pulses consumed by the background state machine.
module sc_level_ctrl
    import sc_game_pkg::*;
#(
    parameter int unsigned NESTS      = DEF_NESTS,
    parameter int unsigned LIVES_INIT = DEF_LIVES_INIT,
    parameter int unsigned LEVEL_MAX  = DEF_LEVEL_MAX,
    parameter int unsigned TICK_BASE  = DEF_TICK_BASE,
    parameter int unsigned TICK_STEP  = DEF_TICK_STEP
) (
    input  logic             SC_STATEMACHINEBACKG_CLOCK_50,
    input  logic             SC_STATEMACHINEBACKG_RESET_InHigh,
    input  logic             start_InLow,
    input  logic             frog_arrive_In,
    input  logic [2:0]       nest_idx_In,
    input  logic             hit_In,
    output logic             t0_OutLow,
    output logic             winf_Out,
    output logic             winl_Out,
    output logic             change_backg_Out,
    output logic             lose_Out,
    output logic             reset_game_Out,
    output logic [2:0]       level_Out,
    output logic [1:0]       lives_Out,
    output logic [NESTS-1:0] nests_Out
);

    localparam int unsigned CNT_W = $clog2(TICK_BASE + 1);

    state_e             state_q;
    logic [NESTS-1:0]   nests_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_q;
    logic               winf_q, winl_q, change_backg_q, lose_q, reset_game_q;

    logic [NESTS-1:0]   nest_bit_c;
    logic               idx_ok_c, taken_c, last_c, die_c, fill_c, levelup_c;
    logic               start_c, play_evt_c, load_c, tick_en_c;
    logic [LEVEL_W-1:0] level_inc_c, period_lvl_c;
    logic [CNT_W-1:0]   period_c;

    // Decode of the arrival/hit strobes and tick-counter controls.
    always_comb begin
        for (int i = 0; i < int'(NESTS); i++) begin
            nest_bit_c[i] = (32'(nest_idx_In) == 32'(i));
        end
        idx_ok_c    = (32'(nest_idx_In) < NESTS);
        taken_c     = |(nests_q & nest_bit_c);
        last_c      = &(nests_q | nest_bit_c);
        die_c       = hit_In || (frog_arrive_In && (!idx_ok_c || taken_c));
        fill_c      = frog_arrive_In && !die_c;
        levelup_c   = fill_c && last_c;
        level_inc_c = (32'(level_q) < (LEVEL_MAX - 1)) ? level_q + LEVEL_W'(1) : level_q;
        start_c     = (state_q == ST_IDLE) && !start_InLow;
        play_evt_c  = (state_q == ST_PLAY) && (die_c || fill_c);
        load_c      = start_c || ((state_q == ST_PLAY) && levelup_c);
        // An event cycle freezes the counter so a tick never lands on a pulse.
        tick_en_c   = (state_q == ST_PLAY) && !play_evt_c;
        if (start_c) begin
            period_lvl_c = '0;
        end else if (levelup_c) begin
            period_lvl_c = level_inc_c;
        end else begin
            period_lvl_c = level_q;
        end
        period_c = CNT_W'(tick_period(TICK_BASE, TICK_STEP, 32'(period_lvl_c)));
    end

    // Game FSM with registered event pulses and score registers.
    always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
        if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
            state_q        <= ST_IDLE;
            nests_q        <= '0;
            level_q        <= '0;
            lives_q        <= LIVES_W'(LIVES_INIT);
            winf_q         <= 1'b0;
            winl_q         <= 1'b0;
            change_backg_q <= 1'b0;
            lose_q         <= 1'b0;
            reset_game_q   <= 1'b0;
        end else begin
            winf_q         <= 1'b0;
            winl_q         <= 1'b0;
            change_backg_q <= 1'b0;
            reset_game_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!start_InLow) begin
                        state_q      <= ST_PLAY;
                        reset_game_q <= 1'b1;
                        level_q      <= '0;
                        lives_q      <= LIVES_W'(LIVES_INIT);
                        nests_q      <= '0;
                    end
                end
                ST_PLAY: begin
                    if (die_c) begin
                        state_q        <= ST_DEAD;
                        change_backg_q <= 1'b1;
                        lives_q        <= lives_q - LIVES_W'(1);
                    end else if (fill_c) begin
                        if (last_c) begin
                            state_q <= ST_LEVELUP;
                            winl_q  <= 1'b1;
                            nests_q <= '0;
                            level_q <= level_inc_c;
                        end else begin
                            state_q <= ST_NEST;
                            winf_q  <= 1'b1;
                            nests_q <= nests_q | nest_bit_c;
                        end
                    end
                end
                ST_NEST, ST_LEVELUP: begin
                    state_q <= ST_PLAY;
                end
                ST_DEAD: begin
                    if (lives_q == '0) begin
                        state_q <= ST_GAMEOVER;
                        lose_q  <= 1'b1;
                    end else begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_GAMEOVER: begin
                    // Wait for button release so a held start never restarts.
                    if (start_InLow) begin
                        state_q <= ST_IDLE;
                        lose_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sc_tick_gen #(
        .CNT_W   (CNT_W),
        .RST_VAL (TICK_BASE - 1)
    ) u_tick_gen (
        .clk_i     (SC_STATEMACHINEBACKG_CLOCK_50),
        .rst_i     (SC_STATEMACHINEBACKG_RESET_InHigh),
        .load_i    (load_c),
        .en_i      (tick_en_c),
        .period_i  (period_c),
        .tick_no_o (t0_OutLow)
    );

    assign winf_Out         = winf_q;
    assign winl_Out         = winl_q;
    assign change_backg_Out = change_backg_q;
    assign lose_Out         = lose_q;
    assign reset_game_Out   = reset_game_q;
    assign level_Out        = level_q;
    assign lives_Out        = lives_q;
    assign nests_Out        = nests_q;

endmodule
